phy_rx_deserializer: RTL and testbench

- Receive-side counterpart of the PHY transmit path. Takes the 1-bit serial stream from the parallel-to-serial stage, searches for COM (0xBC) byte alignment, and declares the link active after a run of consecutive COMs.
- Once active, converts payload bytes back to parallel and distributes them round-robin over four 8-bit lanes with per-lane valid strobes. This rebuilds the data_in0..3 / valid0..3 view for the probador.
- Runs entirely in the clk_32f domain; one serial bit is sampled per clock.

---
 rtl/phy_rx_deserializer.sv | 137 +++++++++++++
 tb/tb_phy_rx_deserializer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/phy_rx_deserializer.sv
// Receive-side deserializer: hunts for COM byte alignment, locks after a run of
// consecutive COMs, then deals payload bytes round-robin over four 8-bit lanes.
module phy_rx_deserializer #(
    parameter logic [7:0]  COM_BYTE   = 8'hBC,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in_serial,
    output logic [7:0] data_out0,
    output logic [7:0] data_out1,
    output logic [7:0] data_out2,
    output logic [7:0] data_out3,
    output logic       valid_out0,
    output logic       valid_out1,
    output logic       valid_out2,
    output logic       valid_out3,
    output logic       idle_out,
    output logic       active
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

    state_t     state_q, state_d;
    logic [7:0] sr_q;
    logic [7:0] sr_next;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] com_cnt_q, com_cnt_d;
    logic [1:0] lane_ptr_q, lane_ptr_d;
    logic [7:0] lane_q [4];
    logic [7:0] lane_d [4];
    logic [3:0] valid_q, valid_d;
    logic       idle_q, idle_d;
    logic       active_q, active_d;
    logic       is_com;

    assign sr_next = {sr_q[6:0], data_in_serial};
    assign is_com  = (sr_next == COM_BYTE);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q + 3'd1;
        com_cnt_d  = com_cnt_q;
        lane_ptr_d = lane_ptr_q;
        lane_d     = lane_q;
        valid_d    = '0;
        idle_d     = 1'b0;
        active_d   = active_q;

        case (state_q)
            HUNT: begin
                // Bit-level search: any edge whose window equals COM becomes a byte boundary.
                bit_cnt_d = '0;
                if (is_com) begin
                    com_cnt_d = 4'd1;
                    if (LOCK_N == 4'd1) begin
                        state_d  = ACTIVE;
                        active_d = 1'b1;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (bit_cnt_q == 3'd7) begin
                    if (is_com) begin
                        com_cnt_d = com_cnt_q + 4'd1;
                        if (com_cnt_q + 4'd1 == LOCK_N) begin
                            state_d  = ACTIVE;
                            active_d = 1'b1;
                        end
                    end else begin
                        com_cnt_d = '0;
                        state_d   = HUNT;
                    end
                end
            end
            ACTIVE: begin
                // COMs while locked are idles; they never consume a lane slot.
                if (bit_cnt_q == 3'd7) begin
                    if (is_com) begin
                        idle_d = 1'b1;
                    end else begin
                        lane_d[lane_ptr_q]  = sr_next;
                        valid_d[lane_ptr_q] = 1'b1;
                        lane_ptr_d          = lane_ptr_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q    <= HUNT;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            com_cnt_q  <= '0;
            lane_ptr_q <= '0;
            lane_q     <= '{default: 8'h00};
            valid_q    <= '0;
            idle_q     <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_next;
            bit_cnt_q  <= bit_cnt_d;
            com_cnt_q  <= com_cnt_d;
            lane_ptr_q <= lane_ptr_d;
            lane_q     <= lane_d;
            valid_q    <= valid_d;
            idle_q     <= idle_d;
            active_q   <= active_d;
        end
    end

    assign data_out0  = lane_q[0];
    assign data_out1  = lane_q[1];
    assign data_out2  = lane_q[2];
    assign data_out3  = lane_q[3];
    assign valid_out0 = valid_q[0];
    assign valid_out1 = valid_q[1];
    assign valid_out2 = valid_q[2];
    assign valid_out3 = valid_q[3];
    assign idle_out   = idle_q;
    assign active     = active_q;

endmodule

// File: tb/tb_phy_rx_deserializer.sv
// Bench for phy_rx_deserializer: directed plan plus random traffic, every cycle
// compared against a bit-history reference model.
module tb_phy_rx_deserializer;

    localparam int LOCK = 4;
    localparam logic [7:0] COM = 8'hBC;

    logic       clk_32f = 1'b0;
    logic       reset = 1'b1;
    logic       data_in_serial = 1'b0;
    logic [7:0] data_out0, data_out1, data_out2, data_out3;
    logic       valid_out0, valid_out1, valid_out2, valid_out3;
    logic       idle_out, active;

    int n_assert = 0;
    int n_fail = 0;

    // Reference model state: window of the last 8 bits, sync flag, bits since last boundary.
    logic [7:0] m_win;
    bit         m_sync, m_active;
    int         m_phase, m_ncom, m_lane;
    logic [7:0] m_data [4];
    logic [3:0] m_valid;
    logic       m_idle;

    phy_rx_deserializer #(.COM_BYTE(COM), .LOCK_COUNT(LOCK)) dut (
        .clk_32f(clk_32f), .reset(reset), .data_in_serial(data_in_serial),
        .data_out0(data_out0), .data_out1(data_out1),
        .data_out2(data_out2), .data_out3(data_out3),
        .valid_out0(valid_out0), .valid_out1(valid_out1),
        .valid_out2(valid_out2), .valid_out3(valid_out3),
        .idle_out(idle_out), .active(active)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_win = '0; m_sync = 0; m_active = 0; m_phase = 0; m_ncom = 0; m_lane = 0;
        for (int i = 0; i < 4; i++) m_data[i] = 8'h00;
        m_valid = '0; m_idle = 0;
    endtask

    task automatic model_step(input logic b);
        m_valid = '0;
        m_idle  = 0;
        m_win   = {m_win[6:0], b};
        if (!m_sync) begin
            if (m_win == COM) begin
                m_sync = 1; m_phase = 0; m_ncom = 1;
                if (LOCK == 1) m_active = 1;
            end
        end else begin
            m_phase = m_phase + 1;
            if (m_phase == 8) begin
                m_phase = 0;
                if (m_active) begin
                    if (m_win == COM) m_idle = 1;
                    else begin
                        m_data[m_lane] = m_win;
                        m_valid[m_lane] = 1'b1;
                        m_lane = (m_lane + 1) % 4;
                    end
                end else if (m_win == COM) begin
                    m_ncom = m_ncom + 1;
                    if (m_ncom >= LOCK) m_active = 1;
                end else begin
                    m_sync = 0; m_ncom = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("active", {31'd0, active}, {31'd0, m_active});
        chk("idle", {31'd0, idle_out}, {31'd0, m_idle});
        chk("valid", {28'd0, valid_out3, valid_out2, valid_out1, valid_out0}, {28'd0, m_valid});
        chk("data", {data_out3, data_out2, data_out1, data_out0},
            {m_data[3], m_data[2], m_data[1], m_data[0]});
    endtask

    task automatic check_zero(input string tag);
        chk(tag, {data_out3, data_out2, data_out1, data_out0}, 32'h0);
        chk(tag, {26'd0, valid_out3, valid_out2, valid_out1, valid_out0, idle_out, active}, 32'h0);
    endtask

    task automatic send_bit(input logic b);
        data_in_serial = b;
        @(posedge clk_32f);
        model_step(b);
        #1;
        check_all();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic do_reset();
        data_in_serial = 1'b0;
        reset = 1'b1;
        #1;
        check_zero("reset_held");
        repeat (2) @(posedge clk_32f);
        #2;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [7:0] rb;
        int         ng;
        model_reset();

        // Reset state, then idle line
        do_reset();
        for (int i = 0; i < 64; i++) send_bit(1'b0);
        check_zero("idle_line");

        // Garbage bits then lock; active must rise exactly on the 35th edge
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_byte(COM); send_byte(COM); send_byte(COM);
        for (int i = 7; i >= 1; i--) send_bit(COM[i]);
        chk("pre_lock_active", {31'd0, active}, 32'd0);
        send_bit(COM[0]);
        chk("lock_active", {31'd0, active}, 32'd1);
        chk("lock_no_idle", {31'd0, idle_out}, 32'd0);

        // Round-robin lane distribution
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55);
        chk("rr_valid0", {31'd0, valid_out0}, 32'd1);
        chk("rr_lanes", {data_out3, data_out2, data_out1, data_out0}, 32'h44332255);

        // Bring pointer back to lane 0, then COM between payload bytes
        send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        send_byte(8'h11);
        chk("com_mid_v0", {31'd0, valid_out0}, 32'd1);
        chk("com_mid_d0", {24'd0, data_out0}, 32'h11);
        send_byte(COM);
        chk("com_mid_idle", {31'd0, idle_out}, 32'd1);
        send_byte(8'h22);
        chk("com_mid_v1", {31'd0, valid_out1}, 32'd1);
        chk("com_mid_d1", {24'd0, data_out1}, 32'h22);

        // Broken COM run returns to hunt; lock only after a fresh run of four
        do_reset();
        send_byte(COM); send_byte(COM); send_byte(8'h00);
        chk("broken_run", {31'd0, active}, 32'd0);
        send_byte(COM); send_byte(COM); send_byte(COM);
        chk("relock_3", {31'd0, active}, 32'd0);
        send_byte(COM);
        chk("relock_4", {31'd0, active}, 32'd1);

        // Asynchronous reset mid-byte while active
        send_byte(8'hA5);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        repeat (2) @(posedge clk_32f);
        #2;
        reset = 1'b0;
        model_reset();
        send_byte(COM); send_byte(COM); send_byte(COM);
        chk("post_rst_3", {31'd0, active}, 32'd0);
        send_byte(COM);
        chk("post_rst_4", {31'd0, active}, 32'd1);

        // Random traffic: random garbage, lock, then mixed payload and idles
        for (int r = 0; r < 3; r++) begin
            do_reset();
            ng = $urandom_range(0, 20);
            for (int i = 0; i < ng; i++) send_bit(1'($urandom_range(0, 1)));
            for (int i = 0; i < LOCK; i++) send_byte(COM);
            for (int i = 0; i < 60; i++) begin
                rb = ($urandom_range(0, 3) == 0) ? COM : 8'($urandom);
                send_byte(rb);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
